// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// The line-fill build is selected with MEM_RESP_BURST_EN.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned LATENCY_DEF = 4;
    localparam int unsigned CNT_WIDTH   = 4;
    localparam int unsigned BURST_LEN   = 4;
    localparam int unsigned BEAT_WIDTH  = 2;
    localparam logic [15:0] LINE_MASK   = 16'hFFF8;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for the responder: combinational read, synchronous write, never reset.
module mem_resp_array #(
    parameter int unsigned WORD_AW    = 15,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_AW-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [WORD_AW-1:0]    raddr,
    output logic [DATA_WIDTH-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << WORD_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Slow data-memory responder: one request at a time, response after LATENCY cycles.
// Optional 4-beat line fills for loads under MEM_RESP_BURST_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LATENCY    = LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_last,
    output logic                  busy
);

    localparam int unsigned WAW = ADDR_WIDTH - 1;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic                    ready_d, valid_d, last_d;
    logic [DATA_WIDTH-1:0]   rdata_d;

    logic [WAW-1:0]          raddr;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_we;

`ifdef MEM_RESP_BURST_EN
    logic [BEAT_WIDTH-1:0]   beat_q, beat_d;
`endif

    // Next-state, latched request and beat sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
`ifdef MEM_RESP_BURST_EN
        beat_d  = beat_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr & ~ADDR_WIDTH'(1);
                    wr_d    = req_wr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_WIDTH'(LATENCY - 1);
                    state_d = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_WIDTH'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
`ifdef MEM_RESP_BURST_EN
                if (!wr_q && (beat_q != BEAT_WIDTH'(BURST_LEN - 1))) begin
                    beat_d = beat_q + 1'b1;
                end else begin
                    beat_d  = '0;
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming cycle; data is fetched one edge early and registered
    always_comb begin
        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
`ifdef MEM_RESP_BURST_EN
        last_d  = valid_d && (wr_d || (beat_d == BEAT_WIDTH'(BURST_LEN - 1)));
        raddr   = WAW'((addr_d & ~ADDR_WIDTH'(~LINE_MASK)) >> 1) | WAW'(beat_d);
`else
        last_d  = valid_d;
        raddr   = WAW'(addr_d >> 1);
`endif
        rdata_d = (valid_d && !wr_d) ? mem_rdata : '0;
    end

    // A store commits on the edge closing its RESP cycle unless that edge is a reset
    assign mem_we = (state_q == RESP) && wr_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            resp_rdata <= '0;
`ifdef MEM_RESP_BURST_EN
            beat_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            req_ready  <= ready_d;
            busy       <= ~ready_d;
            resp_valid <= valid_d;
            resp_last  <= last_d;
            resp_rdata <= rdata_d;
`ifdef MEM_RESP_BURST_EN
            beat_q     <= beat_d;
`endif
        end
    end

    mem_resp_array #(
        .WORD_AW    (WAW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (WAW'(addr_q >> 1)),
        .wdata   (wdata_q),
        .raddr   (raddr),
        .rdata_c (mem_rdata)
    );

endmodule
